// File: rtl/adc_led_scheduler.sv
// Two-channel ADC level-bar scheduler: one DWELL_CYCLES window per channel, led_out registered at window end, inputs never stalled.
// ADC_LED_SCHED_PEAK_EN shows the window max/min pair; undefined, it shows the last valid sample of the window.
module adc_led_scheduler #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BIT_OFFSET       = 4,
  parameter int DWELL_CYCLES     = 62500000,
  parameter int CNT_WIDTH        = 27
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_A_tdata,
  input  logic                        S_AXIS_A_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_B_tdata,
  input  logic                        S_AXIS_B_tvalid,
  input  logic [1:0]                  mode,
  output logic [7:0]                  led_out,
  output logic                        ch_sel,
  output logic                        frame_done
);

  localparam int L = ADC_WIDTH - BIT_OFFSET - 3;
  localparam logic signed [ADC_WIDTH-1:0] SAT_HI  = ADC_WIDTH'((4 << L) - 1);
  localparam logic signed [ADC_WIDTH-1:0] SAT_LO  = ADC_WIDTH'(-(4 << L));
  localparam logic [CNT_WIDTH-1:0]        CNT_END = CNT_WIDTH'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {S_CLEAR, S_ACQ, S_LATCH} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]             mode_r_q, mode_r_d;
  logic                   cur_ch_q, cur_ch_d;
  logic                   acq_ch_q, acq_ch_d;
  logic                   seen_q, seen_d;
  logic [7:0]             led_q, led_d;
  logic                   ch_sel_q, ch_sel_d;
  logic                   done_q, done_d;
  logic signed [ADC_WIDTH-1:0] samp;
  logic                   samp_vld;
  logic                   unused_tdata;

  assign samp     = cur_ch_q ? S_AXIS_B_tdata[ADC_WIDTH-1:0] : S_AXIS_A_tdata[ADC_WIDTH-1:0];
  assign samp_vld = cur_ch_q ? S_AXIS_B_tvalid : S_AXIS_A_tvalid;
  assign unused_tdata = ^{S_AXIS_A_tdata[AXIS_TDATA_WIDTH-1:ADC_WIDTH],
                          S_AXIS_B_tdata[AXIS_TDATA_WIDTH-1:ADC_WIDTH]};

  // Band code 011 lights bit0 and 100 lights bit7: index is 3 minus the signed code.
  function automatic logic [7:0] band_led(input logic signed [ADC_WIDTH-1:0] s);
    logic [2:0] code;
    if (s > SAT_HI)      code = 3'b011;
    else if (s < SAT_LO) code = 3'b100;
    else                 code = s[L+2:L];
    return 8'b1 << (3'd3 - code);
  endfunction

`ifdef ADC_LED_SCHED_PEAK_EN
  logic signed [ADC_WIDTH-1:0] max_q, max_d, min_q, min_d;
`else
  logic signed [ADC_WIDTH-1:0] last_q, last_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_CLEAR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: state_d = S_ACQ;
      S_ACQ:   if (cnt_q == CNT_END) state_d = S_LATCH;
      S_LATCH: state_d = S_CLEAR;
      default: state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    mode_r_d = mode_r_q;
    cur_ch_d = cur_ch_q;
    acq_ch_d = acq_ch_q;
    seen_d   = seen_q;
    led_d    = led_q;
    ch_sel_d = ch_sel_q;
    done_d   = 1'b0;
`ifdef ADC_LED_SCHED_PEAK_EN
    max_d    = max_q;
    min_d    = min_q;
`else
    last_d   = last_q;
`endif
    case (state_q)
      S_CLEAR: begin
        cnt_d    = '0;
        mode_r_d = mode;
        seen_d   = 1'b0;
        // Fixed modes pick their channel without disturbing the auto-alternation pointer.
        if (mode == 2'b01)      cur_ch_d = 1'b0;
        else if (mode == 2'b10) cur_ch_d = 1'b1;
        else                    cur_ch_d = acq_ch_q;
`ifdef ADC_LED_SCHED_PEAK_EN
        max_d = {1'b1, {(ADC_WIDTH-1){1'b0}}};
        min_d = {1'b0, {(ADC_WIDTH-1){1'b1}}};
`endif
      end
      S_ACQ: begin
        cnt_d = cnt_q + 1'b1;
        if (samp_vld) begin
          seen_d = 1'b1;
`ifdef ADC_LED_SCHED_PEAK_EN
          if (samp > max_q) max_d = samp;
          if (samp < min_q) min_d = samp;
`else
          last_d = samp;
`endif
        end
      end
      S_LATCH: begin
        done_d   = 1'b1;
        ch_sel_d = cur_ch_q;
        if (!seen_q || mode_r_q == 2'b11) led_d = 8'h00;
`ifdef ADC_LED_SCHED_PEAK_EN
        else led_d = band_led(max_q) | band_led(min_q);
`else
        else led_d = band_led(last_q);
`endif
        if (mode_r_q == 2'b00) acq_ch_d = ~acq_ch_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mode_r_q <= 2'b00;
      cur_ch_q <= 1'b0;
      acq_ch_q <= 1'b0;
      seen_q   <= 1'b0;
      led_q    <= 8'hFF;
      ch_sel_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef ADC_LED_SCHED_PEAK_EN
      max_q    <= '0;
      min_q    <= '0;
`else
      last_q   <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      mode_r_q <= mode_r_d;
      cur_ch_q <= cur_ch_d;
      acq_ch_q <= acq_ch_d;
      seen_q   <= seen_d;
      led_q    <= led_d;
      ch_sel_q <= ch_sel_d;
      done_q   <= done_d;
`ifdef ADC_LED_SCHED_PEAK_EN
      max_q    <= max_d;
      min_q    <= min_d;
`else
      last_q   <= last_d;
`endif
    end
  end

  assign led_out    = led_q;
  assign ch_sel     = ch_sel_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_adc_led_scheduler.sv
// Randomized and directed stimulus for adc_led_scheduler against a window-level reference model.
module tb_adc_led_scheduler;
  localparam int DW     = 8;
  localparam int PERIOD = DW + 2;
  localparam int L      = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_dat = '0, b_dat = '0;
  logic        a_vld = 1'b0, b_vld = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  led_out;
  logic        ch_sel, frame_done;

  adc_led_scheduler #(
    .ADC_WIDTH(14), .AXIS_TDATA_WIDTH(32), .BIT_OFFSET(4),
    .DWELL_CYCLES(DW), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .S_AXIS_A_tdata(a_dat), .S_AXIS_A_tvalid(a_vld),
    .S_AXIS_B_tdata(b_dat), .S_AXIS_B_tvalid(b_vld),
    .mode(mode), .led_out(led_out), .ch_sel(ch_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: tracks the window phase and the samples collected in it.
  int m_led, m_ch, m_done, m_acq, m_next, m_wmode, m_wch;
  int samples[$];

  function automatic int lvl_led(input int s);
    int code;
    if (s > 4 * (1 << L) - 1)   code = 3;
    else if (s < -4 * (1 << L)) code = -4;
    else                        code = s >>> L;
    return 1 << (3 - code);
  endfunction

  function automatic int window_led();
    int mx, mn;
    if (samples.size() == 0 || m_wmode == 3) return 0;
`ifdef ADC_LED_SCHED_PEAK_EN
    mx = samples[0];
    mn = samples[0];
    foreach (samples[i]) begin
      if (samples[i] > mx) mx = samples[i];
      if (samples[i] < mn) mn = samples[i];
    end
    return lvl_led(mx) | lvl_led(mn);
`else
    mx = samples[samples.size() - 1];
    mn = mx;
    return lvl_led(mx) | lvl_led(mn);
`endif
  endfunction

  task automatic model_edge(input bit r, input int m, input bit av, input int ad,
                            input bit bv, input int bd);
    int ph;
    if (r) begin
      m_led = 8'hFF; m_ch = 0; m_done = 0; m_acq = 0; m_next = 0;
      samples.delete();
      return;
    end
    ph = m_next;
    m_next = (ph + 1) % PERIOD;
    m_done = 0;
    if (ph == 0) begin
      m_wmode = m;
      m_wch = (m == 1) ? 0 : (m == 2) ? 1 : m_acq;
      samples.delete();
    end else if (ph <= DW) begin
      if (m_wch == 0 && av) samples.push_back(ad);
      if (m_wch == 1 && bv) samples.push_back(bd);
    end else begin
      m_done = 1;
      m_ch = m_wch;
      m_led = window_led();
      if (m_wmode == 0) m_acq = 1 - m_acq;
    end
  endtask

  task automatic drive_cycle(input bit r, input logic [1:0] m, input bit av, input int ad,
                             input bit bv, input int bd);
    logic [31:0] t;
    @(negedge clk);
    rst = r; mode = m; a_vld = av; b_vld = bv;
    t = $urandom; t[13:0] = ad[13:0]; a_dat = t;
    t = $urandom; t[13:0] = bd[13:0]; b_dat = t;
    @(posedge clk);
    model_edge(r, int'(m), av, ad, bv, bd);
    #1;
    check("led_out", {24'h0, led_out}, m_led);
    check("ch_sel", {31'h0, ch_sel}, m_ch);
    check("frame_done", {31'h0, frame_done}, m_done);
  endtask

  // One full window starting at its clear cycle; index = cycle within the window.
  int  wa[PERIOD], wb[PERIOD];
  bit  va[PERIOD], vb[PERIOD];

  task automatic clear_plan();
    for (int i = 0; i < PERIOD; i++) begin
      wa[i] = 0; wb[i] = 0; va[i] = 1'b0; vb[i] = 1'b0;
    end
  endtask

  task automatic run_window(input logic [1:0] m);
    for (int i = 0; i < PERIOD; i++) drive_cycle(1'b0, m, va[i], wa[i], vb[i], wb[i]);
    clear_plan();
  endtask

  function automatic int rnd_sample();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 16383)) - 8192;
    return int'($urandom_range(0, 1400)) - 700;
  endfunction

  initial begin
    logic [1:0] rm;
    clear_plan();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 2'b00, 1'b0, 0, 1'b0, 0);

    run_window(2'b00);                         // idle window: blank bar

    va[2] = 1'b1; wa[2] = 0; va[5] = 1'b1; wa[5] = 500; vb[3] = 1'b1; wb[3] = -5000;
    run_window(2'b01);                         // peak on A

    vb[1] = 1'b1; wb[1] = 600; vb[DW] = 1'b1; wb[DW] = -600;
    vb[0] = 1'b1; wb[0] = 0; vb[PERIOD-1] = 1'b1; wb[PERIOD-1] = 0;
    run_window(2'b10);                         // saturation, last-cycle sample, dropped edges

    vb[4] = 1'b1; wb[4] = -1;
    run_window(2'b10);

    for (int w = 0; w < 4; w++) begin          // auto alternation
      for (int i = 0; i < PERIOD; i++) begin
        va[i] = 1'b1; wa[i] = 0; vb[i] = 1'b1; wb[i] = -300;
      end
      run_window(2'b00);
    end

    for (int w = 0; w < 2; w++) begin          // blank mode still frames
      for (int i = 0; i < PERIOD; i++) begin
        va[i] = 1'b1; wa[i] = 400; vb[i] = 1'b1; wb[i] = -400;
      end
      run_window(2'b11);
    end

    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 2'b01, 1'b1, 300, 1'b0, 0);
    drive_cycle(1'b1, 2'b01, 1'b1, 300, 1'b0, 0);
    run_window(2'b01);
    run_window(2'b00);

    rm = 2'b00;
    for (int c = 0; c < 700; c++) begin
      if ($urandom_range(0, 12) == 0) rm = 2'($urandom_range(0, 3));
      drive_cycle($urandom_range(0, 79) == 0, rm,
                  $urandom_range(0, 2) != 0, rnd_sample(),
                  $urandom_range(0, 2) != 0, rnd_sample());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/adc_led_scheduler.md
# adc_led_scheduler

- Time-multiplexes two ADC AXI-Stream channels onto the 8-LED bar.
- Runs fixed-length acquisition windows and tracks the peak (max and min) sample of the selected channel over each window.
- At window end, latches a level bar showing both extremes; in auto mode it alternates channels every window.
- Sits between the two ADC stream outputs and the board LED pins, replacing direct per-sample LED decoding.

## Interface
- ADC_WIDTH, 14: signed ADC sample width, in tdata[ADC_WIDTH-1:0].
- AXIS_TDATA_WIDTH, 32: stream data width.
- BIT_OFFSET, 4: 4 for ±20 V, 0 for ±1 V range; level code is sample bits [ADC_WIDTH-BIT_OFFSET-1 : ADC_WIDTH-BIT_OFFSET-3].
- DWELL_CYCLES, 62500000: acquisition cycles per window (≥1).
- CNT_WIDTH, 27: window counter width; must hold DWELL_CYCLES-1.

Ports:
- clk  in  1  system clock, 125 MHz. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- S_AXIS_A_tdata  in  AXIS_TDATA_WIDTH  channel A samples.
- S_AXIS_A_tvalid  in  1  channel A valid.
- S_AXIS_B_tdata  in  AXIS_TDATA_WIDTH  channel B samples.
- S_AXIS_B_tvalid  in  1  channel B valid.
- mode  in  2  00 auto-alternate, 01 fixed A, 10 fixed B, 11 blank.
- led_out  out  8  LED bar, registered.
- ch_sel  out  1  channel shown by the current led_out (0 = A, 1 = B).
- frame_done  out  1  one-cycle pulse when led_out is updated.

## Operation
- No tready: the block always accepts. Only the selected channel's tvalid cycles are sampled; the other channel is ignored.
- FSM states:
  - S_CLEAR, 1 cycle:
    - max ← most-negative ADC value, min ← most-positive, seen ← 0.
    - Sample mode into mode_r and select the acquisition channel: A for 01, B for 10, acq_ch for 00/11.
    - Window counter ← 0.
  - S_ACQ, exactly DWELL_CYCLES cycles:
    - On each selected tvalid, signed-compare the full ADC_WIDTH sample; update max and min, set seen.
    - A sample arriving in the last S_ACQ cycle is included.
  - S_LATCH, 1 cycle:
    - Register led_out and pulse frame_done.
    - ch_sel ← the channel acquired this window.
    - If mode_r = 00, toggle acq_ch. Then go to S_CLEAR.
- Window period is DWELL_CYCLES+2 cycles. Samples arriving during S_CLEAR or S_LATCH are dropped.
- Level code:
  - L = ADC_WIDTH-BIT_OFFSET-3.
  - Sample > 4·2^L−1 saturates to code 011; sample < −4·2^L saturates to 100.
  - Otherwise code = sample bits [L+2:L].
- LED index = 3 − signed(code): 011→bit0, 000→bit3, 111→bit4, 100→bit7.
- led_out at latch:
  - onehot(code(max)) | onehot(code(min)): one LED if max and min fall in the same band.
  - If seen=0: led_out = 8'h00.
  - If mode_r = 11: led_out = 8'h00, and frame_done still pulses.
- A mode change mid-window takes effect at the next S_CLEAR. Switching into 01/10 overrides acq_ch. Returning to 00 resumes from the current acq_ch.

## Timing
- Reset values:
  - led_out = 8'hFF (lamp test), held until the first S_LATCH.
  - ch_sel = 0, frame_done = 0, acq_ch = A.
  - FSM goes to S_CLEAR on the first cycle after rst deasserts.
- rst asserted mid-window: the partial window is discarded, outputs return to reset values on the next edge, and no frame_done is produced.
- First frame_done occurs DWELL_CYCLES+2 cycles after reset release. led_out and ch_sel change on the same edge that raises frame_done.
- Sample-to-display latency: at most DWELL_CYCLES+1 cycles from a tvalid beat to the led_out update.

## Configuration
- ADC_LED_SCHED_PEAK_EN defined:
  - Window max/min tracking as above.
- Not defined:
  - No max/min registers.
  - The last valid sample of the window is held and displayed as a single LED (onehot of its code).
  - Saturation, seen, blanking and sequencing are unchanged.

## Test plan
All scenarios use DWELL_CYCLES=8, ADC_WIDTH=14, BIT_OFFSET=4 (L=7).

- **Reset:** hold rst 3 cycles, release → led_out=8'hFF, ch_sel=0 until frame_done at cycle 10; with no tvalid, led_out=8'h00 at that pulse.
- **Peak, fixed A:** mode=01, A samples 0 and 500 in one window → led_out=8'h09. With ADC_LED_SCHED_PEAK_EN undefined and last sample 500 → 8'h01.
- **Saturation:** mode=10, B samples 600 and −600 (14'h3DA8) → led_out=8'h81. Single sample −1 → 8'h10.
- **Auto alternation:** mode=00, A constant 0, B constant −300 → led_out alternates 8'h08 (ch_sel=0) and 8'h40 (ch_sel=1) every 10 cycles.
- **Edge and rate:** sample in the last S_ACQ cycle is counted; sample during S_LATCH is dropped. mode=11 → led_out=8'h00, frame_done still every 10 cycles.
- **Mid-window reset:** rst at cycle 5 of a window → no frame_done, led_out=8'hFF, and the next frame_done arrives 10 cycles after release.
